// File: rtl/cordic_rot_seq.sv
// cordic_rot_seq: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Rotates (x_in, y_in) by z_in (signed Q3.29 radians). Results carry the CORDIC
// gain K ~= 1.646760 and are not compensated. Every subtraction is an add of
// the two's complement (~v + 1) of the operand.
//
// Optional feature: define CORDIC_QUAD_EXT_EN to add a PRE state that folds
// |z| > pi/2 into range by negating x/y and shifting z by pi, extending the
// usable angle range to |z| <= pi at the cost of one extra cycle of latency.
module cordic_rot_seq #(
  parameter int DATA_WID_ = 32,
  parameter int ITER      = 16,
  parameter int FRAC      = 29
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WID_-1:0] x_in,
  input  logic [DATA_WID_-1:0] y_in,
  input  logic [DATA_WID_-1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WID_-1:0] x_out,
  output logic [DATA_WID_-1:0] y_out,
  output logic [DATA_WID_-1:0] z_res
);

  // Iteration counter wide enough for the legal range 0..DATA_WID_-3.
  localparam int IW = $clog2(DATA_WID_);
  localparam logic [IW-1:0] LAST_IT = IW'(ITER - 1);

  // Angle constants are tabulated in Q29 and rescaled to FRAC.
  localparam int UP = (FRAC > 29) ? (FRAC - 29) : 0;
  localparam int DN = (FRAC < 29) ? (29 - FRAC) : 0;

`ifdef CORDIC_QUAD_EXT_EN
  localparam logic signed [DATA_WID_-1:0] HALF_PI =
    (DATA_WID_'(32'h3243_F6A9) << UP) >> DN;
  localparam logic signed [DATA_WID_-1:0] NEG_HALF_PI = ~HALF_PI + DATA_WID_'(1);
  localparam logic signed [DATA_WID_-1:0] PI =
    (DATA_WID_'(32'h6487_ED51) << UP) >> DN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2,
    PRE    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;
`endif

  state_t                        state_q;
  logic                          in_ready_q;
  logic                          out_valid_q;
  logic        [IW-1:0]          iter_q;
  logic signed [DATA_WID_-1:0]   x_q, y_q, z_q;
  logic        [DATA_WID_-1:0]   x_out_q, y_out_q, z_res_q;

  logic signed [DATA_WID_-1:0]   xs, ys;
  logic        [DATA_WID_-1:0]   at;
  logic signed [DATA_WID_-1:0]   x_d, y_d, z_d;
`ifdef CORDIC_QUAD_EXT_EN
  logic signed [DATA_WID_-1:0]   xp_d, yp_d, zp_d;
`endif

  // Two's-complement negation, shared by every subtraction in the datapath.
  function automatic logic [DATA_WID_-1:0] twos_neg(input logic [DATA_WID_-1:0] v);
    return ~v + DATA_WID_'(1);
  endfunction

  // round(atan(2^-i) * 2^29); from i = 10 on atan(2^-i) rounds to 2^-i exactly.
  function automatic logic [31:0] atan_q29(input logic [IW-1:0] i);
    logic [31:0] r;
    case (i)
      IW'(0):  r = 32'h1921_FB54;
      IW'(1):  r = 32'h0ED6_3383;
      IW'(2):  r = 32'h07D6_DD7E;
      IW'(3):  r = 32'h03FA_B753;
      IW'(4):  r = 32'h01FF_55BB;
      IW'(5):  r = 32'h00FF_EAAE;
      IW'(6):  r = 32'h007F_FD55;
      IW'(7):  r = 32'h003F_FFAB;
      IW'(8):  r = 32'h001F_FFF5;
      IW'(9):  r = 32'h000F_FFFF;
      default: r = (i <= IW'(29)) ? (32'h2000_0000 >> i) : '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WID_-1:0] atan_rom(input logic [IW-1:0] i);
    return (DATA_WID_'(atan_q29(i)) << UP) >> DN;
  endfunction

  // One micro-rotation: direction follows the sign of the residual angle.
  always_comb begin
    xs  = x_q >>> iter_q;
    ys  = y_q >>> iter_q;
    at  = atan_rom(iter_q);
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (!z_q[DATA_WID_-1]) begin
      x_d = x_q + twos_neg(ys);
      y_d = y_q + xs;
      z_d = z_q + twos_neg(at);
    end else begin
      x_d = x_q + ys;
      y_d = y_q + twos_neg(xs);
      z_d = z_q + at;
    end
  end

`ifdef CORDIC_QUAD_EXT_EN
  // Quadrant fold: rotate by pi up front so the residual lies within +-pi/2.
  always_comb begin
    xp_d = x_q;
    yp_d = y_q;
    zp_d = z_q;
    if (z_q > HALF_PI) begin
      xp_d = twos_neg(x_q);
      yp_d = twos_neg(y_q);
      zp_d = z_q + twos_neg(PI);
    end else if (z_q < NEG_HALF_PI) begin
      xp_d = twos_neg(x_q);
      yp_d = twos_neg(y_q);
      zp_d = z_q + PI;
    end
  end
`endif

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x_in;
            y_q        <= y_in;
            z_q        <= z_in;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
`ifdef CORDIC_QUAD_EXT_EN
            state_q    <= PRE;
`else
            state_q    <= ROTATE;
`endif
          end
        end
`ifdef CORDIC_QUAD_EXT_EN
        PRE: begin
          x_q     <= xp_d;
          y_q     <= yp_d;
          z_q     <= zp_d;
          state_q <= ROTATE;
        end
`endif
        ROTATE: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + IW'(1);
          if (iter_q == LAST_IT) begin
            x_out_q     <= x_d;
            y_out_q     <= y_d;
            z_res_q     <= z_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_res     = z_res_q;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// tb_cordic_rot_seq: directed checks for cordic_rot_seq. Expected outputs are
// K * rotation of the input vector, hand-computed with K = 1.6467602581.
// Tolerances cover the final residual angle (<= atan(2^-15)) and shift truncation.
module tb_cordic_rot_seq;

  localparam int W    = 32;
  localparam int ITER = 16;
`ifdef CORDIC_QUAD_EXT_EN
  localparam int LAT  = ITER + 1;
`else
  localparam int LAT  = ITER;
`endif

  // K * 2^28, and its cos/sin projections at 45 and 30 degrees.
  localparam longint KX   = 64'sd442048841;
  localparam longint C45  = 64'sd312575733;
  localparam longint C30  = 64'sd382825526;
  localparam longint S30  = 64'sd221024421;
  localparam longint TOL  = 64'sd16384;
  localparam longint ZTOL = 64'sd16448;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in, y_in, z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out, y_out, z_res;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int acc_q[$];

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    longint      ex;
    longint      ey;
  } vec_t;

  vec_t tbl[6];

  cordic_rot_seq #(
    .DATA_WID_(W),
    .ITER     (ITER),
    .FRAC     (29)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_res    (z_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and accept log (values read here are pre-edge).
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      last_acc = cyc;
      acc_q.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input longint act, input longint exp,
                          input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +- %0d", nm, act, exp, tol);
    end
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z);
    @(negedge clk);
    for (int n = 0; n < 50; n++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    x_in     = x;
    y_in     = y;
    z_in     = z;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    lat = (cyc - 1) - last_acc;
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_eq({nm, "_valid_cleared"}, longint'(out_valid), 0);
    chk_eq({nm, "_ready_back"}, longint'(in_ready), 1);
  endtask

  initial begin
    int          lat;
    bit          ok;
    bit          stable;
    bit          seen;
    bit          switched;
    int          base;
    int          nres;
    int          diff;
    logic [31:0] cx, cy, cz;
    longint      rx[2];
    longint      ry[2];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;

    tbl[0] = '{x: 32'h1000_0000, y: 32'h0, z: 32'h0,         ex: KX,   ey: 0};
    tbl[1] = '{x: 32'h1000_0000, y: 32'h0, z: 32'h3243_F6A9, ex: 0,    ey: KX};
    tbl[2] = '{x: 32'h1000_0000, y: 32'h0, z: 32'hE6DE_04AC, ex: C45,  ey: -C45};
    tbl[3] = '{x: 32'h1000_0000, y: 32'h0, z: 32'h10C1_5238, ex: C30,  ey: S30};
    tbl[4] = '{x: 32'h0, y: 32'h1000_0000, z: 32'h1921_FB54, ex: -C45, ey: C45};
    tbl[5] = '{x: 32'hF000_0000, y: 32'h0, z: 32'h0,         ex: -KX,  ey: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_in_ready", longint'(in_ready), 1);
    chk_eq("rst_out_valid", longint'(out_valid), 0);
    chk_eq("rst_x_out", sx(x_out), 0);
    chk_eq("rst_y_out", sx(y_out), 0);
    chk_eq("rst_z_res", sx(z_res), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].x, tbl[i].y, tbl[i].z);
      wait_valid(lat, ok);
      chk_eq($sformatf("vec%0d_valid", i), longint'(ok), 1);
      chk_eq($sformatf("vec%0d_latency", i), longint'(lat), longint'(LAT));
      chk_near($sformatf("vec%0d_x", i), sx(x_out), tbl[i].ex, TOL);
      chk_near($sformatf("vec%0d_y", i), sx(y_out), tbl[i].ey, TOL);
      chk_near($sformatf("vec%0d_zres", i), sx(z_res), 0, ZTOL);
      drain($sformatf("vec%0d", i));
    end

    // -pi/4 with a 10-cycle output stall and in_valid asserted throughout
    start_op(32'h1000_0000, 32'h0, 32'hE6DE_04AC);
    wait_valid(lat, ok);
    chk_eq("stall_valid", longint'(ok), 1);
    chk_near("stall_x", sx(x_out), C45, TOL);
    chk_near("stall_y", sx(y_out), -C45, TOL);
    cx = x_out;
    cy = y_out;
    cz = z_res;
    @(negedge clk);
    x_in     = 32'h0ABC_DEF0;
    y_in     = 32'h0123_4567;
    z_in     = 32'h0;
    in_valid = 1'b1;
    base     = acc_q.size();
    stable   = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || x_out !== cx || y_out !== cy || z_res !== cz)
        stable = 1'b0;
    end
    chk_eq("stall_stable", longint'(stable), 1);
    chk_eq("stall_no_accept", longint'(acc_q.size() - base), 0);
    @(negedge clk);
    in_valid = 1'b0;
    drain("stall");

    // Back-to-back with in_valid held and out_ready high
    @(negedge clk);
    out_ready = 1'b1;
    x_in      = tbl[0].x;
    y_in      = tbl[0].y;
    z_in      = tbl[0].z;
    in_valid  = 1'b1;
    base      = acc_q.size();
    nres      = 0;
    switched  = 1'b0;
    for (int n = 0; n < 4 * LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid && nres < 2) begin
        rx[nres] = sx(x_out);
        ry[nres] = sx(y_out);
        nres++;
      end
      if (!switched && acc_q.size() == base + 1) begin
        x_in     = tbl[3].x;
        y_in     = tbl[3].y;
        z_in     = tbl[3].z;
        switched = 1'b1;
      end
      if (acc_q.size() >= base + 2) in_valid = 1'b0;
      if (nres == 2) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_eq("b2b_accepts", longint'(acc_q.size() - base), 2);
    diff = (acc_q.size() >= base + 2) ? acc_q[base+1] - acc_q[base] : -1;
    chk_eq("b2b_interval", longint'(diff), longint'(LAT + 2));
    chk_eq("b2b_results", longint'(nres), 2);
    if (nres < 2) begin
      rx[1] = 0;
      ry[1] = 0;
      if (nres < 1) begin
        rx[0] = 0;
        ry[0] = 0;
      end
    end
    chk_near("b2b_first_x", rx[0], KX, TOL);
    chk_near("b2b_first_y", ry[0], 0, TOL);
    chk_near("b2b_second_x", rx[1], C30, TOL);
    chk_near("b2b_second_y", ry[1], S30, TOL);

    // Reset asserted mid-ROTATE aborts the operation
    start_op(tbl[0].x, tbl[0].y, tbl[0].z);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_in_ready", longint'(in_ready), 1);
    chk_eq("midrst_out_valid", longint'(out_valid), 0);
    chk_eq("midrst_x_out", sx(x_out), 0);
    chk_eq("midrst_y_out", sx(y_out), 0);
    chk_eq("midrst_z_res", sx(z_res), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk_eq("midrst_no_stale", longint'(seen), 0);
    chk_eq("midrst_idle", longint'(in_ready), 1);

    // z = pi: folded into range when the quadrant extension is present,
    // otherwise only required to complete and return to IDLE.
    start_op(32'h1000_0000, 32'h0, 32'h6487_ED51);
    wait_valid(lat, ok);
    chk_eq("pi_valid", longint'(ok), 1);
    chk_eq("pi_latency", longint'(lat), longint'(LAT));
`ifdef CORDIC_QUAD_EXT_EN
    chk_near("pi_x", sx(x_out), -KX, TOL);
    chk_near("pi_y", sx(y_out), 0, TOL);
`endif
    drain("pi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
